// File: rtl/peridot_ft245_responder.sv
// FT245 asynchronous FIFO chip emulator: an external master reads/writes bytes
// through rd_n/wr strobes, backed by Avalon-ST fed RX and drained TX FIFOs.

module peridot_ft245_fifo #(
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic       clock_sig,
    input  logic       reset_sig,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned CNT_W = DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_sig) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
endmodule

module peridot_ft245_responder #(
    parameter int unsigned RXFIFO_DEPTH_BITS = 4,
    parameter int unsigned TXFIFO_DEPTH_BITS = 4,
    parameter int unsigned RECOVER_CYCLES    = 4
) (
    input  logic       clock_sig,
    input  logic       reset_sig,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    inout  wire  [7:0] ft_d,
    input  logic       ft_rd_n,
    input  logic       ft_wr,
    output logic       ft_rxf_n,
    output logic       ft_txe_n,
    output logic       proto_err
);
    localparam int unsigned REC_EFF = (RECOVER_CYCLES == 0) ? 1 : RECOVER_CYCLES;
    localparam int unsigned CW      = (REC_EFF > 1) ? $clog2(REC_EFF) : 1;
    localparam logic [CW-1:0] REC_LOAD = CW'(REC_EFF - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RECOVER} state_t;

    state_t        state_q;
    logic [CW-1:0] rec_cnt_q;
    logic          rd_s0_q, rd_s1_q, wr_s0_q, wr_s1_q;
    logic [7:0]    d_stage_q, d_hold_q, tx_push_data_q;
    logic          rd_arm_q, rxf_n_q, txe_n_q, proto_err_q;
    logic          rx_pop_q, tx_push_q, ready_en_q;

    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic [7:0] rx_head;
    logic       rd_fall, rd_rise, wr_rise, wr_fall;

    assign rd_fall = rd_s1_q & ~rd_s0_q;
    assign rd_rise = ~rd_s1_q & rd_s0_q;
    assign wr_rise = wr_s0_q & ~wr_s1_q;
    assign wr_fall = wr_s1_q & ~wr_s0_q;

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            rd_s0_q    <= 1'b1;
            rd_s1_q    <= 1'b1;
            wr_s0_q    <= 1'b0;
            wr_s1_q    <= 1'b0;
            d_stage_q  <= '0;
            d_hold_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            rd_s0_q    <= ft_rd_n;
            rd_s1_q    <= rd_s0_q;
            wr_s0_q    <= ft_wr;
            wr_s1_q    <= wr_s0_q;
            d_stage_q  <= ft_d;
            ready_en_q <= 1'b1;
            if (wr_s0_q) d_hold_q <= d_stage_q;
        end
    end

    // FIFO push/pop are issued as registered pulses, so counts settle while
    // the FSM sits in RECOVER and IDLE always sees post-transfer occupancy.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q        <= ST_IDLE;
            rec_cnt_q      <= '0;
            rd_arm_q       <= 1'b0;
            rxf_n_q        <= 1'b1;
            txe_n_q        <= 1'b1;
            proto_err_q    <= 1'b0;
            rx_pop_q       <= 1'b0;
            tx_push_q      <= 1'b0;
            tx_push_data_q <= '0;
        end else begin
            proto_err_q <= 1'b0;
            rx_pop_q    <= 1'b0;
            tx_push_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    rxf_n_q  <= rx_empty;
                    txe_n_q  <= tx_full;
                    rd_arm_q <= ~rx_empty;
                    if (rd_fall && !rx_empty) begin
                        state_q     <= ST_READ;
                        proto_err_q <= wr_rise;
                    end else begin
                        if (wr_rise && !tx_full) state_q <= ST_WRITE;
                        proto_err_q <= rd_fall | (wr_rise & tx_full);
                    end
                end
                ST_READ: begin
                    proto_err_q <= wr_rise | wr_fall;
                    if (rd_rise) begin
                        rx_pop_q  <= 1'b1;
                        rd_arm_q  <= 1'b0;
                        rec_cnt_q <= REC_LOAD;
                        rxf_n_q   <= 1'b1;
                        txe_n_q   <= 1'b1;
                        state_q   <= ST_RECOVER;
                    end
                end
                ST_WRITE: begin
                    proto_err_q <= rd_fall;
                    if (wr_fall) begin
                        tx_push_q      <= 1'b1;
                        tx_push_data_q <= d_hold_q;
                        rd_arm_q       <= 1'b0;
                        rec_cnt_q      <= REC_LOAD;
                        rxf_n_q        <= 1'b1;
                        txe_n_q        <= 1'b1;
                        state_q        <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    rxf_n_q     <= 1'b1;
                    txe_n_q     <= 1'b1;
                    proto_err_q <= rd_fall | wr_rise;
                    if (rec_cnt_q == '0) state_q <= ST_IDLE;
                    else rec_cnt_q <= rec_cnt_q - CW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    peridot_ft245_fifo #(.DEPTH_BITS(RXFIFO_DEPTH_BITS)) u_rx_fifo (
        .clock_sig   (clock_sig),
        .reset_sig   (reset_sig),
        .push_i      (in_valid & in_ready),
        .push_data_i (in_data),
        .pop_i       (rx_pop_q),
        .head_o      (rx_head),
        .empty_o     (rx_empty),
        .full_o      (rx_full)
    );

    peridot_ft245_fifo #(.DEPTH_BITS(TXFIFO_DEPTH_BITS)) u_tx_fifo (
        .clock_sig   (clock_sig),
        .reset_sig   (reset_sig),
        .push_i      (tx_push_q),
        .push_data_i (tx_push_data_q),
        .pop_i       (out_valid & out_ready),
        .head_o      (out_data),
        .empty_o     (tx_empty),
        .full_o      (tx_full)
    );

    // Drive enable mixes the raw strobe with rd_arm so data follows rd_n combinationally.
    assign ft_d      = (rd_arm_q & ~ft_rd_n) ? rx_head : 'z;
    assign in_ready  = ready_en_q & ~rx_full;
    assign out_valid = ~tx_empty;
    assign ft_rxf_n  = rxf_n_q;
    assign ft_txe_n  = txe_n_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_peridot_ft245_responder.sv
// Directed bench for peridot_ft245_responder: acts as FT245 master plus
// Avalon-ST producer/consumer; the bus is pulled up so an undriven ft_d reads 0xFF.

module tb_peridot_ft245_responder;
    logic       clock_sig = 1'b0;
    logic       reset_sig;
    logic       in_valid, out_ready, ft_rd_n, ft_wr;
    logic [7:0] in_data;
    logic       in_ready, out_valid, ft_rxf_n, ft_txe_n, proto_err;
    logic [7:0] out_data;
    wire  [7:0] ft_d;
    logic [7:0] tb_d;
    logic       tb_d_en;

    int errors   = 0;
    int checks   = 0;
    int perr_cnt = 0;
    int perr_base;

    always #5 clock_sig = ~clock_sig;

    assign ft_d = tb_d_en ? tb_d : 'z;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (ft_d[g]);
    end

    always @(negedge clock_sig) if (proto_err === 1'b1) perr_cnt++;

    peridot_ft245_responder #(
        .RXFIFO_DEPTH_BITS (4),
        .TXFIFO_DEPTH_BITS (4),
        .RECOVER_CYCLES    (4)
    ) dut (
        .clock_sig (clock_sig),
        .reset_sig (reset_sig),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ft_d      (ft_d),
        .ft_rd_n   (ft_rd_n),
        .ft_wr     (ft_wr),
        .ft_rxf_n  (ft_rxf_n),
        .ft_txe_n  (ft_txe_n),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rxf_low();
        int n = 0;
        while (ft_rxf_n !== 1'b0 && n < 200) begin @(negedge clock_sig); n++; end
        chk("wait_rxf_low", 8'(ft_rxf_n), 8'h00);
    endtask

    task automatic wait_txe_low();
        int n = 0;
        while (ft_txe_n !== 1'b0 && n < 200) begin @(negedge clock_sig); n++; end
        chk("wait_txe_low", 8'(ft_txe_n), 8'h00);
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin @(negedge clock_sig); n++; end
        chk("wait_in_ready", 8'(in_ready), 8'h01);
    endtask

    task automatic av_push(input logic [7:0] b);
        wait_in_ready();
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock_sig);
        in_valid = 1'b0;
    endtask

    task automatic ft_read(input string tag, input logic [7:0] exp);
        wait_rxf_low();
        ft_rd_n = 1'b0;
        repeat (3) @(negedge clock_sig);
        chk(tag, ft_d, exp);
        ft_rd_n = 1'b1;
        repeat (3) @(negedge clock_sig);
    endtask

    task automatic ft_write(input logic [7:0] b);
        wait_txe_low();
        tb_d    = b;
        tb_d_en = 1'b1;
        ft_wr   = 1'b1;
        repeat (3) @(negedge clock_sig);
        ft_wr   = 1'b0;
        tb_d_en = 1'b0;
        repeat (3) @(negedge clock_sig);
    endtask

    initial begin
        reset_sig = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ft_rd_n   = 1'b1;
        ft_wr     = 1'b0;
        tb_d      = '0;
        tb_d_en   = 1'b0;

        // Reset state
        repeat (3) @(negedge clock_sig);
        chk("rst_in_ready", 8'(in_ready), 8'h00);
        chk("rst_rxf_n", 8'(ft_rxf_n), 8'h01);
        chk("rst_txe_n", 8'(ft_txe_n), 8'h01);
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_proto_err", 8'(proto_err), 8'h00);
        chk("rst_ft_d_z", ft_d, 8'hFF);
        reset_sig = 1'b0;
        @(negedge clock_sig);
        chk("post_rst_in_ready", 8'(in_ready), 8'h01);
        @(negedge clock_sig);
        chk("post_rst_txe_n", 8'(ft_txe_n), 8'h00);
        chk("post_rst_rxf_n", 8'(ft_rxf_n), 8'h01);

        // Single read with flag latency and recovery hold
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clock_sig);
        in_valid = 1'b0;
        chk("rxf_lat1", 8'(ft_rxf_n), 8'h01);
        @(negedge clock_sig);
        chk("rxf_lat2", 8'(ft_rxf_n), 8'h00);
        ft_rd_n = 1'b0;
        #1 chk("rd_data_early", ft_d, 8'hA5);
        repeat (5) @(negedge clock_sig);
        chk("rd_data_late", ft_d, 8'hA5);
        ft_rd_n = 1'b1;
        @(negedge clock_sig);
        chk("rd_rxf_frozen", 8'(ft_rxf_n), 8'h00);
        @(negedge clock_sig);
        chk("rec_rxf_n", 8'(ft_rxf_n), 8'h01);
        chk("rec_txe_n", 8'(ft_txe_n), 8'h01);
        chk("rd_release_z", ft_d, 8'hFF);
        repeat (8) @(negedge clock_sig);
        chk("after_rd_rxf_n", 8'(ft_rxf_n), 8'h01);
        chk("after_rd_txe_n", 8'(ft_txe_n), 8'h00);
        chk("after_rd_perr", 8'(perr_cnt), 8'h00);

        // Burst write fills TX, then drain in order
        for (int i = 1; i <= 16; i++) ft_write(8'(i));
        repeat (8) @(negedge clock_sig);
        chk("tx_full_txe_n", 8'(ft_txe_n), 8'h01);
        chk("tx_full_valid", 8'(out_valid), 8'h01);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", out_data, 8'(i));
            @(negedge clock_sig);
        end
        out_ready = 1'b0;
        chk("drained_valid", 8'(out_valid), 8'h00);
        @(negedge clock_sig);
        chk("drained_txe_n", 8'(ft_txe_n), 8'h00);
        chk("burst_perr", 8'(perr_cnt), 8'h00);

        // Wrap-around: 40 bytes interleaved through the 16-deep RX FIFO
        for (int k = 0; k < 20; k++) begin
            av_push(8'(k * 14 + 3));
            av_push(8'(k * 14 + 10));
            ft_read("wrap_data", 8'(k * 14 + 3));
            ft_read("wrap_data", 8'(k * 14 + 10));
        end
        chk("wrap_perr", 8'(perr_cnt), 8'h00);

        // Read with RX empty: no drive, one error pulse, no pop
        repeat (10) @(negedge clock_sig);
        perr_base = perr_cnt;
        ft_rd_n = 1'b0;
        #1 chk("empty_rd_z_early", ft_d, 8'hFF);
        repeat (4) @(negedge clock_sig);
        chk("empty_rd_z_late", ft_d, 8'hFF);
        ft_rd_n = 1'b1;
        repeat (4) @(negedge clock_sig);
        chk("empty_rd_perr", 8'(perr_cnt - perr_base), 8'h01);
        chk("empty_rd_rxf_n", 8'(ft_rxf_n), 8'h01);
        av_push(8'h5A);
        ft_read("no_pop_data", 8'h5A);

        // rd and wr together in IDLE: READ wins, single error pulse
        av_push(8'h66);
        wait_rxf_low();
        perr_base = perr_cnt;
        ft_rd_n = 1'b0;
        ft_wr   = 1'b1;
        #1 chk("both_rd_data", ft_d, 8'h66);
        repeat (4) @(negedge clock_sig);
        ft_rd_n = 1'b1;
        repeat (2) @(negedge clock_sig);
        ft_wr = 1'b0;
        repeat (10) @(negedge clock_sig);
        chk("both_perr_once", 8'(perr_cnt - perr_base), 8'h01);
        chk("both_no_tx", 8'(out_valid), 8'h00);
        chk("both_rx_empty", 8'(ft_rxf_n), 8'h01);

        // Full RX: pop and pending push on adjacent clocks
        for (int i = 0; i < 16; i++) av_push(8'(8'h80 + i));
        chk("full_in_ready", 8'(in_ready), 8'h00);
        wait_rxf_low();
        in_valid = 1'b1;
        in_data  = 8'h90;
        ft_rd_n  = 1'b0;
        #1 chk("full_rd_head", ft_d, 8'h80);
        repeat (3) @(negedge clock_sig);
        ft_rd_n = 1'b1;
        @(negedge clock_sig);
        chk("pop_rdy_r1", 8'(in_ready), 8'h00);
        @(negedge clock_sig);
        chk("pop_rdy_r2", 8'(in_ready), 8'h00);
        @(negedge clock_sig);
        chk("pop_rdy_r3", 8'(in_ready), 8'h01);
        @(negedge clock_sig);
        chk("pop_rdy_r4", 8'(in_ready), 8'h00);
        in_valid = 1'b0;
        repeat (10) @(negedge clock_sig);
        for (int i = 1; i < 16; i++) ft_read("full_order", 8'(8'h80 + i));
        ft_read("full_last", 8'h90);

        // Reset in the middle of a read
        ft_write(8'h77);
        chk("pre_rst_out_valid", 8'(out_valid), 8'h01);
        av_push(8'h3C);
        wait_rxf_low();
        ft_rd_n = 1'b0;
        #1 chk("mid_rd_data", ft_d, 8'h3C);
        repeat (2) @(negedge clock_sig);
        #2 reset_sig = 1'b1;
        #1;
        chk("mid_rst_ft_d_z", ft_d, 8'hFF);
        chk("mid_rst_rxf_n", 8'(ft_rxf_n), 8'h01);
        chk("mid_rst_txe_n", 8'(ft_txe_n), 8'h01);
        chk("mid_rst_out_valid", 8'(out_valid), 8'h00);
        chk("mid_rst_in_ready", 8'(in_ready), 8'h00);
        @(negedge clock_sig);
        ft_rd_n = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        repeat (2) @(negedge clock_sig);
        chk("rel_in_ready", 8'(in_ready), 8'h01);
        chk("rel_txe_n", 8'(ft_txe_n), 8'h00);
        repeat (6) @(negedge clock_sig);
        chk("rel_rx_empty", 8'(ft_rxf_n), 8'h01);
        ft_rd_n = 1'b0;
        #1 chk("rel_rd_z", ft_d, 8'hFF);
        repeat (3) @(negedge clock_sig);
        ft_rd_n = 1'b1;
        repeat (4) @(negedge clock_sig);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/peridot_ft245_responder.md
Name: peridot_ft245_responder

Overview:
- Device-side counterpart of the FT245 asynchronous FIFO phy: emulates the FT245 chip.
- Accepts rd_n/wr strobes from an external FT245 master and drives ft_rxf_n/ft_txe_n.
- Serves read data from an RX FIFO filled by an Avalon-ST sink, and pushes written bytes into a TX FIFO drained by an Avalon-ST source.
- Used for FPGA-to-FPGA links and as the bench responder for host-bridge regression.

Parameters:
- RXFIFO_DEPTH_BITS, 4: RX FIFO depth = 2^N bytes (master-read direction); legal range 1..8.
- TXFIFO_DEPTH_BITS, 4: TX FIFO depth = 2^N bytes (master-write direction); legal range 1..8.
- RECOVER_CYCLES, 4: clocks ft_rxf_n/ft_txe_n are held inactive after each completed transfer; values of 0 are treated as 1.

Ports:
- clock_sig  in  1  clock; all logic on rising edge
- reset_sig  in  1  reset, asynchronous, active-high
- in_valid  in  1  Avalon-ST sink valid: byte to be read by master
- in_data  in  8  Avalon-ST sink data
- in_ready  out  1  sink ready = RX FIFO not full
- out_valid  out  1  Avalon-ST source valid = TX FIFO not empty
- out_data  out  8  TX FIFO head
- out_ready  in  1  source ready; pop on valid&ready
- ft_d  inout  8  FT245 data bus
- ft_rd_n  in  1  read strobe from master, active-low
- ft_wr  in  1  write strobe from master, active-high; data latched on falling edge
- ft_rxf_n  out  1  low = byte available to read
- ft_txe_n  out  1  low = space available to write
- proto_err  out  1  one-clock pulse on a protocol violation

Behaviour:
- Reset (async): both FIFOs empty; FSM in IDLE; ft_rxf_n=1, ft_txe_n=1; ft_d=Z; in_ready=0 during reset and 1 after; out_valid=0; proto_err=0. Reset mid-transfer aborts the transfer with no push or pop, and tristates ft_d immediately.
- Input sync: ft_rd_n and ft_wr each pass through a 2-FF synchronizer. Stage 0 is the first flop and stage 1 the second.
  - rd_fall = s1 & ~s0 on the rd_n active level (low); rd_rise is the inverse.
  - wr_fall = wr_s1 & ~wr_s0.
- Write data capture:
  - d_stage samples ft_d every clock.
  - d_hold <= d_stage on every clock where wr_s0=1.
  - At wr_fall, d_hold is pushed. This requires ft_wr high for at least 2 clocks, with data valid for the whole high period.
- Read data drive:
  - ft_d = (rd_arm & ~ft_rd_n) ? RX head : Z. The enable combines async ft_rd_n with registered rd_arm, so data appears combinationally after rd_n falls.
  - rd_arm is set in IDLE when the RX FIFO is non-empty, and cleared on entering RECOVER or on reset.
  - RX head is stable until the pop.
- FSM states IDLE, READ, WRITE, RECOVER:
  - IDLE:
    - ft_rxf_n = RX empty; ft_txe_n = TX full.
    - rd_fall with RX non-empty -> READ.
    - Otherwise, wr rising (wr_s0 & ~wr_s1) with TX not full -> WRITE.
    - If rd and wr are both detected in the same clock, READ wins and proto_err pulses.
  - READ:
    - ft_rxf_n and ft_txe_n stay at their IDLE values, frozen.
    - rd_rise -> pop RX, rd_arm=0, load counter with RECOVER_CYCLES-1, go to RECOVER.
    - Any wr activity in READ -> proto_err pulse, wr ignored.
  - WRITE:
    - wr_fall -> push d_hold into TX, load counter, go to RECOVER.
    - rd_fall in WRITE -> proto_err, ignored.
  - RECOVER:
    - ft_rxf_n=1 and ft_txe_n=1.
    - Counter decrements; at 0 -> IDLE.
    - Strobes seen here -> proto_err, ignored.
- Violations in IDLE:
  - rd_fall with RX empty: no drive, no pop, proto_err.
  - wr rising with TX full: byte dropped, proto_err.
- FIFOs:
  - Register arrays with N-bit pointers that wrap modulo 2^N, plus an N+1-bit count.
  - Simultaneous push and pop on the same FIFO: count unchanged, both operations happen.
  - Push on a full FIFO never occurs: in_ready gates the RX push, and the FSM gates the TX push.
- Latency:
  - Avalon push to ft_rxf_n low: 2 clocks (count update, then registered flag).
  - wr falling edge to out_valid: 3 clocks (2 sync stages plus push register).
- Outputs ft_rxf_n, ft_txe_n and proto_err are registered.

Test Plan:
- Single read: push 0xA5 via sink -> ft_rxf_n low within 2 clocks. Master pulls rd_n low for 5 clocks -> ft_d=0xA5 while low. After the rd_n rise, ft_rxf_n is high for 4 clocks, then stays high because RX is empty.
- Burst write: master writes 0x01..0x10 (16 bytes, wr 3 high / 3 low) with out_ready=0 -> ft_txe_n high after 16th byte. Then drain with out_ready=1 -> out_data 0x01..0x10 in order, ft_txe_n returns low.
- Wrap-around: 40 interleaved sink pushes and master reads, 16-deep FIFO -> every byte read back in order, no proto_err.
- Violations:
  - rd_n low with RX empty -> ft_d stays Z, proto_err pulse, no pop.
  - rd and wr asserted together in IDLE -> READ taken, proto_err=1 for exactly one clock.
- Reset mid-read: assert reset_sig while rd_n is low and 0x3C is driven -> ft_d Z immediately, ft_rxf_n=ft_txe_n=1, out_valid=0. After release, in_ready=1 and RX is empty.
- Simultaneous push/pop on full RX (16 entries): in_valid=1 on the same clock as the rd_n-rise pop -> count stays 16 only if in_ready was 1, else 15. in_ready rises exactly one clock after the pop.
